// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
//   Shared definitions for the M stage of the pipelined RISC-V core:
//   datapath widths, ResultSrc encodings, the memory-access FSM state
//   encoding and a small decode helper used by the stage and its W register.
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // ResultSrc encodings (select of the writeback mux in the W stage)
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  // Memory-access FSM state encodings
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_REQ       = ST_REQ,
    S_WAIT_RESP = ST_WAIT_RESP
  } state_e;

  // An instruction touches data memory if it stores or if it writes back
  // load data.
  function automatic logic is_access(input logic       mem_write,
                                     input logic [1:0] result_src);
    return mem_write | (result_src == RES_MEM);
  endfunction

endpackage

// File: rtl/mem_access_stage_mem_wb.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
//   MEM/WB pipeline register. Captures the M-stage bundle every clock, or a
//   bubble (all fields zero, so RegWrite is off) while the M stage stalls.
//
//   Ports
//     clk, rst           clock (rising edge), asynchronous active-low reset
//     i_bubble           1 = load a bubble instead of the M bundle
//     i_result_src .. i_pc_plus4   M-stage bundle (read data already muxed)
//     o_result_src .. o_pc_plus4   registered W-stage bundle
// -----------------------------------------------------------------------------
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_bubble,
  input  logic [1:0]        i_result_src,
  input  logic              i_reg_write,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_read_data,
  input  logic [REG_W-1:0]  i_rd,
  input  logic [DATA_W-1:0] i_ext_imm,
  input  logic [DATA_W-1:0] i_pc_plus4,
  output logic [1:0]        o_result_src,
  output logic              o_reg_write,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_read_data,
  output logic [REG_W-1:0]  o_rd,
  output logic [DATA_W-1:0] o_ext_imm,
  output logic [DATA_W-1:0] o_pc_plus4
);

  logic [1:0]        r_result_src;
  logic              r_reg_write;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_read_data;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_ext_imm;
  logic [DATA_W-1:0] r_pc_plus4;

  // ---- M -> W stage boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result_src <= '0;
      r_reg_write  <= 1'b0;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_rd         <= '0;
      r_ext_imm    <= '0;
      r_pc_plus4   <= '0;
    end else if (i_bubble) begin
      r_result_src <= '0;
      r_reg_write  <= 1'b0;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_rd         <= '0;
      r_ext_imm    <= '0;
      r_pc_plus4   <= '0;
    end else begin
      r_result_src <= i_result_src;
      r_reg_write  <= i_reg_write;
      r_alu_result <= i_alu_result;
      r_read_data  <= i_read_data;
      r_rd         <= i_rd;
      r_ext_imm    <= i_ext_imm;
      r_pc_plus4   <= i_pc_plus4;
    end
  end

  assign o_result_src = r_result_src;
  assign o_reg_write  = r_reg_write;
  assign o_alu_result = r_alu_result;
  assign o_read_data  = r_read_data;
  assign o_rd         = r_rd;
  assign o_ext_imm    = r_ext_imm;
  assign o_pc_plus4   = r_pc_plus4;

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   M stage of the pipelined RISC-V core. Consumes the EX/MEM bundle, runs the
//   load/store handshake with a variable-latency data memory, stalls the front
//   of the pipe (StallM) while an access is outstanding and registers the
//   MEM/WB bundle.
//
//   Parameter
//     TIMEOUT   cycles a load may sit in WAIT_RESP before it is forced to
//               complete with zero data (0 disables the timeout)
//
//   Ports
//     clk, rst                       clock, asynchronous active-low reset
//     ResultSrcM .. PCPlus4M         M-stage bundle from EX/MEM
//     dmem_req/we/addr/wdata         request channel to data memory
//     dmem_ready                     request accepted (when dmem_req=1)
//     dmem_rvalid/rdata              load response channel
//     StallM                         hold PC, IF/ID, ID/EX and EX/MEM
//     ResultSrcW .. PCPlus4W         registered MEM/WB bundle
//     TimeoutErr                     sticky flag, set when a load times out
// -----------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // M-stage bundle
  input  logic [1:0]        ResultSrcM,
  input  logic              MemWriteM,
  input  logic              RegWriteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  RdM,
  input  logic [DATA_W-1:0] ExtImmM,
  input  logic [DATA_W-1:0] PCPlus4M,
  // data memory
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  // hazard control
  output logic              StallM,
  // W-stage bundle
  output logic [1:0]        ResultSrcW,
  output logic              RegWriteW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [REG_W-1:0]  RdW,
  output logic [DATA_W-1:0] ExtImmW,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic              TimeoutErr
);

  // Counter is wide enough to hold TIMEOUT itself.
  localparam int               CNT_W      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic             TIMEOUT_EN = (TIMEOUT > 0);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_timeout_err;

  logic              w_access;
  logic              w_req;
  logic              w_complete;
  logic              w_load_done;
  logic              w_timeout;
  logic              w_cnt_clr;
  logic              w_bubble;
  logic [DATA_W-1:0] w_read_data;

  assign w_access  = is_access(MemWriteM, ResultSrcM);
  assign w_cnt_inc = r_cnt + CNT_ONE;

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, request and completion decode. The EX/MEM outputs are frozen
  // by StallM, so the access seen in REQ/WAIT_RESP is the one that started it.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_complete  = 1'b0;
    w_load_done = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_clr   = 1'b0;
    unique case (r_state)
      S_IDLE, S_REQ: begin
        w_req = (r_state == S_REQ) | w_access;
        if (w_access) begin
          if (dmem_ready) begin
            if (MemWriteM) begin
              // store is done once the memory accepts it
              w_complete  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_clr   = 1'b1;
              w_state_nxt = S_WAIT_RESP;
            end
          end else begin
            w_state_nxt = S_REQ;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_RESP: begin
        if (dmem_rvalid) begin
          w_complete  = 1'b1;
          w_load_done = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (TIMEOUT_EN && (w_cnt_inc == CNT_LIMIT)) begin
          // the TIMEOUT-th waiting cycle without a response
          w_complete  = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- response timeout counter ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (TIMEOUT_EN && (r_state == S_WAIT_RESP)) begin
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_timeout_err <= 1'b0;
    else if (w_timeout) r_timeout_err <= 1'b1;
  end

  // Request and stall are gated by reset so nothing leaks out while the
  // core is held.
  assign dmem_req   = rst & w_req;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALUResultM;
  assign dmem_wdata = WriteDataM;
  assign StallM     = rst & w_access & ~w_complete;

  // A stalled cycle must not write back; the instruction writes back once, on
  // the cycle it completes. Timed-out loads return zero.
  assign w_bubble    = w_access & ~w_complete;
  assign w_read_data = w_load_done ? dmem_rdata : '0;

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .i_bubble     (w_bubble),
    .i_result_src (ResultSrcM),
    .i_reg_write  (RegWriteM),
    .i_alu_result (ALUResultM),
    .i_read_data  (w_read_data),
    .i_rd         (RdM),
    .i_ext_imm    (ExtImmM),
    .i_pc_plus4   (PCPlus4M),
    .o_result_src (ResultSrcW),
    .o_reg_write  (RegWriteW),
    .o_alu_result (ALUResultW),
    .o_read_data  (ReadDataW),
    .o_rd         (RdW),
    .o_ext_imm    (ExtImmW),
    .o_pc_plus4   (PCPlus4W)
  );

  assign TimeoutErr = r_timeout_err;

endmodule
